// File: rtl/gpu_pkg.sv
// Shared GPU front-end definitions: input-assembler FSM states and frame constants.
package gpu_pkg;

  typedef enum logic [1:0] {
    IA_HUNT    = 2'd0,
    IA_PAYLOAD = 2'd1,
    IA_CHECK   = 2'd2
  } ia_state_e;

  localparam logic [7:0] IA_HEADER         = 8'hA5;
  localparam int         IA_PAYLOAD_LEN    = 55;
  // Pad slot: still strobed out, the register decoder drops it.
  localparam int         IA_PAD_IDX        = 50;
  localparam int         IA_TIMEOUT_CYCLES = 20000;

endpackage

// File: rtl/ia_gap_timer.sv
// Saturating 16-bit idle counter; expire_o marks the last idle cycle before a link timeout.
module ia_gap_timer #(
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  // Expiry fires on the cycle where the count would reach TIMEOUT_CYCLES-1.
  localparam logic [15:0] EXPIRE_AT = 16'(TIMEOUT_CYCLES - 2);

  logic [15:0] gap_q, gap_d;

  always_comb begin
    gap_d = gap_q;
    if (clr_i || !en_i) begin
      gap_d = '0;
    end else if (gap_q != 16'hFFFF) begin
      gap_d = gap_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_d;
    end
  end

  assign expire_o = en_i && !clr_i && (gap_q == EXPIRE_AT);

endmodule

// File: rtl/ia_frame_sequencer.sv
// Turns the UART byte stream into indexed triangle-register writes and a frame-ready pulse.
module ia_frame_sequencer
  import gpu_pkg::*;
#(
  parameter logic [7:0] HEADER         = IA_HEADER,
  parameter int         PAYLOAD_LEN    = IA_PAYLOAD_LEN,
  parameter int         TIMEOUT_CYCLES = IA_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [7:0] read_data,
  output logic [5:0] idx,
  output logic       update_reg,
  output logic       pc_ready,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [5:0] LAST_IDX = 6'(PAYLOAD_LEN - 1);

  ia_state_e  state_q;
  logic [5:0] cnt_q;
  logic [7:0] csum_q;
  logic [7:0] read_data_q;
  logic [5:0] idx_q;
  logic       update_reg_q;
  logic       pc_ready_q;
  logic       frame_err_q;
  logic       busy_q;
  logic       expire;

  ia_gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (rx_done),
    .en_i    (state_q != IA_HUNT),
    .expire_o(expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IA_HUNT;
      cnt_q        <= '0;
      csum_q       <= '0;
      read_data_q  <= '0;
      idx_q        <= '0;
      update_reg_q <= 1'b0;
      pc_ready_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      update_reg_q <= 1'b0;
      pc_ready_q   <= 1'b0;
      case (state_q)
        IA_HUNT: begin
          if (rx_done && rx_data == HEADER) begin
            state_q <= IA_PAYLOAD;
            cnt_q   <= '0;
            csum_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        IA_PAYLOAD: begin
          // A header value inside the payload is plain data; no resync.
          if (rx_done) begin
            read_data_q  <= rx_data;
            idx_q        <= cnt_q;
            update_reg_q <= 1'b1;
            csum_q       <= csum_q ^ rx_data;
            cnt_q        <= cnt_q + 6'd1;
            if (cnt_q == LAST_IDX) begin
              state_q <= IA_CHECK;
            end
          end else if (expire) begin
            state_q     <= IA_HUNT;
            frame_err_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        IA_CHECK: begin
          if (rx_done) begin
            if (rx_data == csum_q) begin
              pc_ready_q  <= 1'b1;
              frame_err_q <= 1'b0;
            end else begin
              frame_err_q <= 1'b1;
            end
            state_q <= IA_HUNT;
            busy_q  <= 1'b0;
          end else if (expire) begin
            state_q     <= IA_HUNT;
            frame_err_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q <= IA_HUNT;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign read_data  = read_data_q;
  assign idx        = idx_q;
  assign update_reg = update_reg_q;
  assign pc_ready   = pc_ready_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_ia_frame_sequencer.sv
// Scoreboard bench for ia_frame_sequencer: stimulus pushes expected writes/pulses, a negedge monitor pops them.
module tb_ia_frame_sequencer;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [7:0] read_data;
  logic [5:0] idx;
  logic       update_reg;
  logic       pc_ready;
  logic       frame_err;
  logic       busy;

  ia_frame_sequencer #(
    .HEADER        (8'hA5),
    .PAYLOAD_LEN   (55),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .read_data (read_data),
    .idx       (idx),
    .update_reg(update_reg),
    .pc_ready  (pc_ready),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc;
    logic [5:0] idx;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (update_reg && pc_ready) begin
        n_total++;
        $display("FAIL overlap: update_reg and pc_ready both high");
      end
      if (update_reg || pc_ready) begin
        exp_t e;
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_event: upd=%0b pc=%0b idx=%0d data=%02h with nothing expected",
                   update_reg, pc_ready, idx, read_data);
        end else begin
          e = exp_q.pop_front();
          if (e.pc == pc_ready && e.pc != update_reg && (e.pc || (e.idx == idx && e.data == read_data)))
            n_pass++;
          else
            $display("FAIL event: got pc=%0b idx=%0d data=%02h expected pc=%0b idx=%0d data=%02h",
                     pc_ready, idx, read_data, e.pc, e.idx, e.data);
        end
      end
    end
  end

  task automatic put(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_done = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input int i, input logic [7:0] d);
    exp_t e;
    e.pc   = 1'b0;
    e.idx  = 6'(i);
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_pc();
    exp_t e;
    e.pc   = 1'b1;
    e.idx  = '0;
    e.data = '0;
    exp_q.push_back(e);
  endtask

  // Sends header, payload and checksum (xor'd with cmod to corrupt it).
  task automatic send_frame(input logic [7:0] pl[55], input logic [7:0] cmod, input bit b2b);
    logic [7:0] cs;
    cs = 8'h00;
    put(8'hA5);
    if (!b2b) idle(1);
    for (int i = 0; i < 55; i++) begin
      push_wr(i, pl[i]);
      cs = cs ^ pl[i];
      put(pl[i]);
      if (!b2b) idle(1);
    end
    if (cmod == 8'h00) push_pc();
    put(cs ^ cmod);
    idle(2);
  endtask

  logic [7:0] pl[55];
  logic [7:0] cs_run;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    rx_done = 1'b0;
    rx_data = 8'h00;
    for (int i = 0; i < 55; i++) pl[i] = 8'(i + 1);
    repeat (2) @(posedge clk);
    #1;
    check("rst_read_data", int'(read_data), 0);
    check("rst_idx", int'(idx), 0);
    check("rst_update_reg", int'(update_reg), 0);
    check("rst_pc_ready", int'(pc_ready), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    idle(2);

    // Good frame.
    send_frame(pl, 8'h00, 1'b0);
    check("good_frame_err", int'(frame_err), 0);
    check("good_busy", int'(busy), 0);

    // Bad checksum, then a good frame clears the error.
    send_frame(pl, 8'h01, 1'b0);
    check("bad_frame_err", int'(frame_err), 1);
    send_frame(pl, 8'h00, 1'b0);
    check("recover_frame_err", int'(frame_err), 0);

    // Noise before header.
    put(8'h00); idle(1);
    put(8'hFF); idle(1);
    put(8'h5A); idle(2);
    check("noise_busy", int'(busy), 0);
    send_frame(pl, 8'h00, 1'b0);
    check("noise_frame_err", int'(frame_err), 0);

    // Byte arriving exactly on the expiry cycle is accepted.
    cs_run = 8'h00;
    put(8'hA5); idle(1);
    check("hdr_busy", int'(busy), 1);
    for (int i = 0; i < 10; i++) begin
      push_wr(i, pl[i]);
      cs_run = cs_run ^ pl[i];
      put(pl[i]);
      if (i != 9) idle(1);
    end
    rx_done = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    push_wr(10, pl[10]);
    cs_run = cs_run ^ pl[10];
    put(pl[10]);
    idle(1);
    check("edge_busy", int'(busy), 1);
    check("edge_frame_err", int'(frame_err), 0);
    for (int i = 11; i < 55; i++) begin
      push_wr(i, pl[i]);
      cs_run = cs_run ^ pl[i];
      put(pl[i]);
      idle(1);
    end
    push_pc();
    put(cs_run);
    idle(2);
    check("edge_end_frame_err", int'(frame_err), 0);

    // Timeout: silence after 10 bytes, error exactly 15 cycles after the last byte.
    put(8'hA5); idle(1);
    for (int i = 0; i < 10; i++) begin
      push_wr(i, pl[i]);
      put(pl[i]);
      if (i != 9) idle(1);
    end
    rx_done = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    check("to_early_frame_err", int'(frame_err), 0);
    check("to_early_busy", int'(busy), 1);
    @(posedge clk);
    #1;
    check("to_frame_err", int'(frame_err), 1);
    check("to_busy", int'(busy), 0);
    put(8'h33); idle(2);
    check("to_hunt_busy", int'(busy), 0);

    // Reset mid-frame.
    put(8'hA5); idle(1);
    for (int i = 0; i < 20; i++) begin
      push_wr(i, pl[i]);
      put(pl[i]);
      idle(1);
    end
    check("mid_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("mrst_read_data", int'(read_data), 0);
    check("mrst_idx", int'(idx), 0);
    check("mrst_update_reg", int'(update_reg), 0);
    check("mrst_pc_ready", int'(pc_ready), 0);
    check("mrst_frame_err", int'(frame_err), 0);
    check("mrst_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    put(8'h11);
    idle(3);
    check("post_rst_busy", int'(busy), 0);

    // Back-to-back with header value as data.
    pl[3] = 8'hA5;
    pl[7] = 8'hA5;
    send_frame(pl, 8'h00, 1'b1);
    check("b2b_frame_err", int'(frame_err), 0);
    check("b2b_busy", int'(busy), 0);

    idle(3);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
